request_encoder: RTL and testbench
==================================

# request_encoder

Sequential counterpart of the 2-to-4 one-hot decoder: collects one-hot/multi-hot request bits into a pending register and emits each pending request as a binary index over a valid/ready handshake, lowest index first. It sits between request sources such as status flags or interrupt lines and any consumer that wants a binary index (for example, one that feeds a decoder).

## Interface
- N, default 4: number of request lines; N ≥ 2.
- W, default $clog2(N): width of the binary index (2 for N=4).

- clock  input  1  rising-edge clock
- reset_L  input  1  asynchronous, active-low reset
- en_L  input  1  active-low capture enable; when 1, `onehot` is ignored
- onehot  input  N  request bits, sampled every edge, multi-hot allowed
- ready  input  1  consumer accepts `binary` when `valid && ready`
- valid  output  1  `binary` holds a request index
- binary  output  W  index of the request being presented
- pending  output  N  registered pending vector, excluding the presented index

## Operation
- Registers:
  - `pending[N-1:0]`
  - `binary[W-1:0]`
  - `valid`
  - FSM `state` ∈ {IDLE, PRESENT}
- Capture: `cap = en_L ? '0 : onehot`.
- Update rule: `pending_next = (pending & ~take) | cap`.
  - `take` is the one-hot of the index loaded into the output this cycle, or 0 if nothing is loaded.
  - Set wins over clear: a request captured on the same edge that its index is taken stays pending and is served again later.
- Load condition: `load = (state==IDLE || ready) && (pending != 0)`.
  - On load: `binary <= index of lowest set bit of pending`, `valid <= 1`, `take` = that bit.
- FSM transitions:
  - IDLE, pending==0: stay IDLE, valid=0.
  - IDLE, pending!=0: load, go to PRESENT.
  - PRESENT, ready=0: hold `binary` and `valid` stable; no load. `pending` still accumulates captures.
  - PRESENT, ready=1, pending!=0: load the next index back-to-back, stay in PRESENT.
  - PRESENT, ready=1, pending==0: valid<=0, go to IDLE. `binary` keeps its last value (don't-care while valid=0).
- Loads use the registered `pending` only. A request never reaches `valid` combinationally or in the same cycle it is captured.
- An index already being presented can be re-requested. It re-enters `pending` and is emitted again after the current transfer.
- Multiple requests on the same line before service coalesce into one emission.
- en_L=1 blocks capture only. Already-pending requests keep draining.

## Timing
- Reset (reset_L=0, asynchronous): pending=0, valid=0, binary=0, state=IDLE, effective immediately. Remains so while reset_L=0.
  - Reset mid-operation discards all pending and presented requests, with no emission.
  - First capture happens at the first rising edge after reset_L deasserts.
- Latency: request sampled at edge k → pending set after edge k → valid=1 with its index after edge k+1.
- Throughput: with ready held 1, one index per cycle. A capture of `1011` at edge k yields binary 0, 1, 3 after edges k+1, k+2, k+3, and valid=0 after edge k+4.
- Handshake: a transfer occurs at an edge where valid=1 and ready=1. `binary` is stable from valid rising until the transfer. ready may be high while valid=0 (ignored).
- All outputs are registered; none depends combinationally on inputs.

## Structure
- Package `request_encoder_pkg`:
  - typedef enum logic {IDLE, PRESENT} `re_state_t`
  - default constants N_DEF=4, W_DEF=2
- Sub-module `lowbit_encoder`: purely combinational, N→W lowest-set-bit encoder with a `found` output. Instantiated once on `pending`.

## Test plan
- Reset: assert reset_L=0 mid-cycle with pending=`0110`, valid=1 → valid=0, pending=`0000`, binary=0 immediately, before the next edge.
- Single request: en_L=0, onehot=`0100` for one cycle, ready=1 → valid=1 for exactly one cycle, two edges later, with binary=2; then valid=0.
- Multi-hot drain: onehot=`1011` for one cycle, ready=1 → binary 0, 1, 3 on consecutive cycles, then valid=0, pending=`0000`.
- Backpressure: onehot=`0110` for one cycle, ready=0 for 3 cycles → binary=1 held with valid=1 and pending=`0100`; then ready=1 → transfers of 1 then 2.
- Enable: en_L=1, onehot=`1111` for 5 cycles → valid stays 0. With pending=`0001` preset, en_L=1 → index 0 is still emitted.
- Re-request: while binary=1 is presented with ready=0, pulse onehot=`0010` → after ready=1, index 1 is emitted twice.

Source files
------------

// File: rtl/request_encoder_pkg.sv
// Shared types and default sizing for request_encoder.
//   re_state_t : output-stage state (IDLE = nothing presented, PRESENT = index on o_binary)
//   N_DEF/W_DEF: default request-line count and index width
package request_encoder_pkg;

  typedef enum logic {IDLE, PRESENT} re_state_t;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned W_DEF = 2;

endpackage

// File: rtl/lowbit_encoder.sv
// Combinational lowest-set-bit encoder.
//   i_vec   [N-1:0] : input vector
//   o_index [W-1:0] : index of the lowest set bit (0 when none set)
//   o_found         : any bit of i_vec is set
module lowbit_encoder #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_index,
  output logic         o_found
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    o_index = '0;
    o_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_index = W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/request_encoder.sv
// Collects request bits into a pending register and emits each pending request as a binary
// index over a valid/ready handshake, lowest index first.
//   i_clock            : rising-edge clock
//   i_reset_L          : asynchronous active-low reset
//   i_en_L             : active-low capture enable (1 = ignore i_onehot)
//   i_onehot  [N-1:0]  : request bits, multi-hot allowed
//   i_ready            : consumer accepts o_binary when o_valid && i_ready
//   o_valid            : o_binary holds a request index
//   o_binary  [W-1:0]  : index being presented
//   o_pending [N-1:0]  : pending requests, excluding the presented index
module request_encoder
  import request_encoder_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         i_clock,
  input  logic         i_reset_L,
  input  logic         i_en_L,
  input  logic [N-1:0] i_onehot,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_binary,
  output logic [N-1:0] o_pending
);

  localparam logic [N-1:0] LsbOne = N'(1);

  re_state_t      r_state;
  logic [N-1:0]   r_pending;
  logic [W-1:0]   r_binary;
  logic           r_valid;

  logic [N-1:0]   w_cap;
  logic [W-1:0]   w_index;
  logic           w_found;
  logic           w_load;
  logic [N-1:0]   w_take;

  lowbit_encoder #(
    .N (N),
    .W (W)
  ) u_lowbit (
    .i_vec   (r_pending),
    .o_index (w_index),
    .o_found (w_found)
  );

  assign w_cap  = i_en_L ? '0 : i_onehot;
  // Only registered pending feeds the output, so a request never reaches o_valid in the
  // cycle it is captured.
  assign w_load = ((r_state == IDLE) || i_ready) && w_found;
  assign w_take = w_load ? (LsbOne << w_index) : '0;

  always_ff @(posedge i_clock or negedge i_reset_L) begin
    if (!i_reset_L) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_binary  <= '0;
      r_valid   <= 1'b0;
    end else begin
      // Capture is OR-ed in after the clear, so a re-request of the taken index survives.
      r_pending <= (r_pending & ~w_take) | w_cap;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_binary <= w_index;
            r_valid  <= 1'b1;
            r_state  <= PRESENT;
          end
        end
        PRESENT: begin
          if (i_ready) begin
            if (w_load) begin
              r_binary <= w_index;
              r_valid  <= 1'b1;
            end else begin
              // o_binary keeps its last value; it is don't-care while o_valid is low.
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid   = r_valid;
  assign o_binary  = r_binary;
  assign o_pending = r_pending;

endmodule

// File: tb/tb_request_encoder.sv
// Self-checking bench for request_encoder: directed scenarios followed by random traffic,
// all compared against a behavioural model of pending requests and the presented index.
module tb_request_encoder;
  import request_encoder_pkg::*;

  localparam int unsigned N = N_DEF;
  localparam int unsigned W = W_DEF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en_l = 1'b1;
  logic [N-1:0] onehot = '0;
  logic         ready = 1'b0;
  logic         valid;
  logic [W-1:0] binary;
  logic [N-1:0] pending;

  int tests = 0;
  int fails = 0;

  // Model: set of outstanding request lines plus the presented index.
  bit m_pend[N];
  bit m_valid;
  int m_bin;

  request_encoder #(
    .N (N),
    .W (W)
  ) dut (
    .i_clock   (clk),
    .i_reset_L (rst_n),
    .i_en_L    (en_l),
    .i_onehot  (onehot),
    .i_ready   (ready),
    .o_valid   (valid),
    .o_binary  (binary),
    .o_pending (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] m_vec();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_valid = 1'b0;
    m_bin   = 0;
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_edge();
    int lo;
    if (!m_valid || ready) begin
      lo = -1;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i]) lo = i;
      if (lo >= 0) begin
        m_valid    = 1'b1;
        m_bin      = lo;
        m_pend[lo] = 1'b0;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (!en_l) for (int i = 0; i < N; i++) if (onehot[i]) m_pend[i] = 1'b1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, 32'(valid), 32'(m_valid));
    check({tag, ".binary"}, 32'(binary), 32'(m_bin));
    check({tag, ".pending"}, 32'(pending), 32'(m_vec()));
  endtask

  task automatic step(input logic e, input logic [N-1:0] oh, input logic r, input string tag);
    en_l   = e;
    onehot = oh;
    ready  = r;
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    model_reset();
    #3;
    check("reset.valid", 32'(valid), 32'd0);
    check("reset.pending", 32'(pending), 32'd0);
    check("reset.binary", 32'(binary), 32'd0);
    #9 rst_n = 1'b1;

    // Single request: valid for one cycle, two edges after capture.
    step(1'b0, 4'b0100, 1'b1, "single0");
    check("single0.novalid", 32'(valid), 32'd0);
    step(1'b1, 4'b0000, 1'b1, "single1");
    check("single1.valid", 32'(valid), 32'd1);
    check("single1.binary", 32'(binary), 32'd2);
    step(1'b1, 4'b0000, 1'b1, "single2");
    check("single2.valid", 32'(valid), 32'd0);

    // Multi-hot drain 1011 -> 0, 1, 3.
    step(1'b0, 4'b1011, 1'b1, "drain_cap");
    step(1'b1, 4'b0000, 1'b1, "drain0");
    check("drain0.binary", 32'(binary), 32'd0);
    step(1'b1, 4'b0000, 1'b1, "drain1");
    check("drain1.binary", 32'(binary), 32'd1);
    step(1'b1, 4'b0000, 1'b1, "drain3");
    check("drain3.binary", 32'(binary), 32'd3);
    check("drain3.valid", 32'(valid), 32'd1);
    step(1'b1, 4'b0000, 1'b1, "drain_end");
    check("drain_end.valid", 32'(valid), 32'd0);
    check("drain_end.pending", 32'(pending), 32'd0);

    // Backpressure: 0110 with ready low holds index 1.
    step(1'b0, 4'b0110, 1'b0, "bp_cap");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0000, 1'b0, "bp_hold");
      check("bp_hold.binary", 32'(binary), 32'd1);
      check("bp_hold.pending", 32'(pending), 32'b0100);
    end
    step(1'b1, 4'b0000, 1'b1, "bp_go1");
    check("bp_go1.binary", 32'(binary), 32'd2);
    step(1'b1, 4'b0000, 1'b1, "bp_go2");
    check("bp_go2.valid", 32'(valid), 32'd0);

    // Enable high blocks capture.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b1111, 1'b1, "en_block");
      check("en_block.valid", 32'(valid), 32'd0);
    end
    // Already-pending request drains with enable high.
    step(1'b0, 4'b0001, 1'b0, "en_pre");
    step(1'b1, 4'b1111, 1'b1, "en_drain");
    check("en_drain.valid", 32'(valid), 32'd1);
    check("en_drain.binary", 32'(binary), 32'd0);
    step(1'b1, 4'b1111, 1'b1, "en_drain_end");

    // Re-request of the presented index is emitted again.
    step(1'b0, 4'b0010, 1'b0, "rr_cap");
    step(1'b1, 4'b0000, 1'b0, "rr_show");
    step(1'b0, 4'b0010, 1'b0, "rr_again");
    check("rr_again.pending", 32'(pending), 32'b0010);
    step(1'b1, 4'b0000, 1'b1, "rr_second");
    check("rr_second.valid", 32'(valid), 32'd1);
    check("rr_second.binary", 32'(binary), 32'd1);
    step(1'b1, 4'b0000, 1'b1, "rr_end");
    check("rr_end.valid", 32'(valid), 32'd0);

    // Asynchronous reset mid-cycle with pending=0110, valid=1.
    step(1'b0, 4'b0010, 1'b0, "rst_a");
    step(1'b0, 4'b0110, 1'b0, "rst_b");
    check("rst_b.pending", 32'(pending), 32'b0110);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst.valid", 32'(valid), 32'd0);
    check("async_rst.pending", 32'(pending), 32'd0);
    check("async_rst.binary", 32'(binary), 32'd0);
    #2 rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3) == 0), N'($urandom), ($urandom_range(2) != 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
